// File: rtl/pp_pkg.sv
// Shared pipeline widths and control-bundle bit positions for the
// decode/issue slice.
package pp_pkg;
  localparam int DATA_W     = 32;
  localparam int IDX_W      = 4;
  localparam int NUM_REGS   = 16;
  localparam int CTRL_W     = 8;
  localparam int CTRL_REGWR = 0;
endpackage

// File: rtl/reg_file.sv
// 16-entry architectural register file: one write port and two
// combinational read ports with write-through. A synchronous reset clears it.
module reg_file
  import pp_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int IDX_W_P  = IDX_W,
  parameter int NREGS_P  = NUM_REGS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [IDX_W_P-1:0]  wr_index,
  input  logic [DATA_W_P-1:0] wr_data,
  input  logic [IDX_W_P-1:0]  rd0_index,
  input  logic [IDX_W_P-1:0]  rd1_index,
  output logic [DATA_W_P-1:0] rd0_data,
  output logic [DATA_W_P-1:0] rd1_data
);

  logic [DATA_W_P-1:0] regs_q [NREGS_P];
  logic [DATA_W_P-1:0] regs_d [NREGS_P];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_index] = wr_data;
  end

  // Reset takes priority, so a write arriving in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS_P; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd0_data = (wr_en && (wr_index == rd0_index)) ? wr_data : regs_q[rd0_index];
    rd1_data = (wr_en && (wr_index == rd1_index)) ? wr_data : regs_q[rd1_index];
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode-to-execute boundary: register file reads, RAW interlock against
// EX/MEM producers, the ID/EX pipeline register and the interlock counter.
module decode_issue_stage
  import pp_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int IDX_W_P  = IDX_W,
  parameter int CTRL_W_P = CTRL_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [IDX_W_P-1:0]  id_rs0,
  input  logic [IDX_W_P-1:0]  id_rs1,
  input  logic                id_use0,
  input  logic                id_use1,
  input  logic [IDX_W_P-1:0]  id_rd,
  input  logic [DATA_W_P-1:0] id_imm,
  input  logic [DATA_W_P-1:0] id_pc,
  input  logic [CTRL_W_P-1:0] id_ctrl,
  input  logic                mem_valid,
  input  logic                mem_regwr,
  input  logic [IDX_W_P-1:0]  mem_rd,
  input  logic                wb_en,
  input  logic [IDX_W_P-1:0]  wb_index,
  input  logic [DATA_W_P-1:0] wb_data,
  input  logic                ex_hold,
  input  logic                ex_flush,
  output logic                stall_id,
  output logic                ex_valid,
  output logic [DATA_W_P-1:0] ex_rs0_data,
  output logic [DATA_W_P-1:0] ex_rs1_data,
  output logic [IDX_W_P-1:0]  ex_rs0,
  output logic [IDX_W_P-1:0]  ex_rs1,
  output logic [IDX_W_P-1:0]  ex_rd,
  output logic [DATA_W_P-1:0] ex_imm,
  output logic [DATA_W_P-1:0] ex_pc,
  output logic [CTRL_W_P-1:0] ex_ctrl,
  output logic [31:0]         stall_cycles
);

  logic [DATA_W_P-1:0] rs0_rdata, rs1_rdata;
  logic                hit_ex, hit_mem, interlock;

  logic                ex_valid_q, ex_valid_d;
  logic [DATA_W_P-1:0] ex_rs0_data_q, ex_rs0_data_d;
  logic [DATA_W_P-1:0] ex_rs1_data_q, ex_rs1_data_d;
  logic [IDX_W_P-1:0]  ex_rs0_q, ex_rs0_d;
  logic [IDX_W_P-1:0]  ex_rs1_q, ex_rs1_d;
  logic [IDX_W_P-1:0]  ex_rd_q, ex_rd_d;
  logic [DATA_W_P-1:0] ex_imm_q, ex_imm_d;
  logic [DATA_W_P-1:0] ex_pc_q, ex_pc_d;
  logic [CTRL_W_P-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [31:0]         stall_cycles_q, stall_cycles_d;

  reg_file #(
    .DATA_W_P (DATA_W_P),
    .IDX_W_P  (IDX_W_P),
    .NREGS_P  (NUM_REGS)
  ) u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wb_en),
    .wr_index  (wb_index),
    .wr_data   (wb_data),
    .rd0_index (id_rs0),
    .rd1_index (id_rs1),
    .rd0_data  (rs0_rdata),
    .rd1_data  (rs1_rdata)
  );

  // WB is not a hazard source: write-through already covers it.
  always_comb begin
    hit_ex    = ex_valid_q && ex_ctrl_q[CTRL_REGWR] &&
                ((id_use0 && (id_rs0 == ex_rd_q)) || (id_use1 && (id_rs1 == ex_rd_q)));
    hit_mem   = mem_valid && mem_regwr &&
                ((id_use0 && (id_rs0 == mem_rd)) || (id_use1 && (id_rs1 == mem_rd)));
    interlock = id_valid && (hit_ex || hit_mem);
    stall_id  = interlock || ex_hold;
  end

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_rs0_data_d = ex_rs0_data_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs0_d      = ex_rs0_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rd_d       = ex_rd_q;
    ex_imm_d      = ex_imm_q;
    ex_pc_d       = ex_pc_q;
    ex_ctrl_d     = ex_ctrl_q;
    if (ex_flush) begin
      ex_valid_d    = 1'b0;
      ex_rs0_data_d = '0;
      ex_rs1_data_d = '0;
      ex_rs0_d      = '0;
      ex_rs1_d      = '0;
      ex_rd_d       = '0;
      ex_imm_d      = '0;
      ex_pc_d       = '0;
      ex_ctrl_d     = '0;
    end else if (ex_hold) begin
      ex_valid_d = ex_valid_q;
    end else if (interlock) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d    = id_valid;
      ex_rs0_data_d = rs0_rdata;
      ex_rs1_data_d = rs1_rdata;
      ex_rs0_d      = id_rs0;
      ex_rs1_d      = id_rs1;
      ex_rd_d       = id_rd;
      ex_imm_d      = id_imm;
      ex_pc_d       = id_pc;
      ex_ctrl_d     = id_ctrl;
    end
  end

  // Only genuine bubbles count; cycles absorbed by hold or flush do not.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (interlock && !ex_hold && !ex_flush && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q     <= 1'b0;
      ex_rs0_data_q  <= '0;
      ex_rs1_data_q  <= '0;
      ex_rs0_q       <= '0;
      ex_rs1_q       <= '0;
      ex_rd_q        <= '0;
      ex_imm_q       <= '0;
      ex_pc_q        <= '0;
      ex_ctrl_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rs0_data_q  <= ex_rs0_data_d;
      ex_rs1_data_q  <= ex_rs1_data_d;
      ex_rs0_q       <= ex_rs0_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rd_q        <= ex_rd_d;
      ex_imm_q       <= ex_imm_d;
      ex_pc_q        <= ex_pc_d;
      ex_ctrl_q      <= ex_ctrl_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    ex_valid     = ex_valid_q;
    ex_rs0_data  = ex_rs0_data_q;
    ex_rs1_data  = ex_rs1_data_q;
    ex_rs0       = ex_rs0_q;
    ex_rs1       = ex_rs1_q;
    ex_rd        = ex_rd_q;
    ex_imm       = ex_imm_q;
    ex_pc        = ex_pc_q;
    ex_ctrl      = ex_ctrl_q;
    stall_cycles = stall_cycles_q;
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: reset state, write-through, the
// distance-1/2/3 interlock cases, flush, hold and counter saturation.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use0, id_use1;
  logic [3:0]  id_rs0, id_rs1, id_rd;
  logic [31:0] id_imm, id_pc;
  logic [7:0]  id_ctrl;
  logic        mem_valid, mem_regwr;
  logic [3:0]  mem_rd;
  logic        wb_en;
  logic [3:0]  wb_index;
  logic [31:0] wb_data;
  logic        ex_hold, ex_flush;
  logic        stall_id, ex_valid;
  logic [31:0] ex_rs0_data, ex_rs1_data, ex_imm, ex_pc;
  logic [3:0]  ex_rs0, ex_rs1, ex_rd;
  logic [7:0]  ex_ctrl;
  logic [31:0] stall_cycles;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs0       (id_rs0),
    .id_rs1       (id_rs1),
    .id_use0      (id_use0),
    .id_use1      (id_use1),
    .id_rd        (id_rd),
    .id_imm       (id_imm),
    .id_pc        (id_pc),
    .id_ctrl      (id_ctrl),
    .mem_valid    (mem_valid),
    .mem_regwr    (mem_regwr),
    .mem_rd       (mem_rd),
    .wb_en        (wb_en),
    .wb_index     (wb_index),
    .wb_data      (wb_data),
    .ex_hold      (ex_hold),
    .ex_flush     (ex_flush),
    .stall_id     (stall_id),
    .ex_valid     (ex_valid),
    .ex_rs0_data  (ex_rs0_data),
    .ex_rs1_data  (ex_rs1_data),
    .ex_rs0       (ex_rs0),
    .ex_rs1       (ex_rs1),
    .ex_rd        (ex_rd),
    .ex_imm       (ex_imm),
    .ex_pc        (ex_pc),
    .ex_ctrl      (ex_ctrl),
    .stall_cycles (stall_cycles)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the edge before anything is sampled.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one decode-slot instruction.
  task automatic applyStimulus(input logic vld, input logic [3:0] rs0, input logic u0,
                               input logic [3:0] rs1, input logic u1, input logic [3:0] rd,
                               input logic [7:0] ctrl, input logic [31:0] imm, input logic [31:0] pc);
    id_valid = vld;
    id_rs0   = rs0;
    id_use0  = u0;
    id_rs1   = rs1;
    id_use1  = u1;
    id_rd    = rd;
    id_ctrl  = ctrl;
    id_imm   = imm;
    id_pc    = pc;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    mem_valid = 1'b0; mem_regwr = 1'b0; mem_rd = '0;
    wb_en = 1'b0; wb_index = '0; wb_data = '0;
    ex_hold = 1'b0; ex_flush = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 32'h0, 32'h0);
    stepCycle();
    stepCycle();
    reset = 1'b0;
    checkOutput("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
    checkOutput("reset_stall_cycles", stall_cycles, 32'd0);

    // All registers read as zero after reset.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, i[3:0], 1'b0, 4'(15 - i), 1'b0, 4'd0, 8'h00, 32'h0, 32'h0);
      stepCycle();
      checkOutput($sformatf("reset_rd0_r%0d", i), ex_rs0_data, 32'd0);
      checkOutput($sformatf("reset_rd1_r%0d", 15 - i), ex_rs1_data, 32'd0);
    end

    // Write-through on both ports in the write cycle.
    wb_en = 1'b1; wb_index = 4'd5; wb_data = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 4'd1, 8'h00, 32'h0, 32'h0);
    stepCycle();
    wb_en = 1'b0;
    checkOutput("wt_rs0", ex_rs0_data, 32'hDEAD_BEEF);
    checkOutput("wt_rs1", ex_rs1_data, 32'hDEAD_BEEF);
    checkOutput("wt_valid", {31'b0, ex_valid}, 32'd1);
    applyStimulus(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd1, 8'h00, 32'h0, 32'h0);
    stepCycle();
    checkOutput("persist_r5", ex_rs0_data, 32'hDEAD_BEEF);

    // Distance 1: producer r3, consumer reads r3 on port 1.
    applyStimulus(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 8'h01, 32'h0, 32'h40);
    stepCycle();
    checkOutput("d1_prod_rd", {28'b0, ex_rd}, 32'd3);
    applyStimulus(1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 4'd7, 8'h00, 32'h0, 32'h44);
    checkOutput("d1_stall_a", {31'b0, stall_id}, 32'd1);
    stepCycle();
    checkOutput("d1_bubble_a", {31'b0, ex_valid}, 32'd0);
    checkOutput("d1_cnt_a", stall_cycles, 32'd1);
    mem_valid = 1'b1; mem_regwr = 1'b1; mem_rd = 4'd3;
    #1;
    checkOutput("d1_stall_b", {31'b0, stall_id}, 32'd1);
    stepCycle();
    checkOutput("d1_bubble_b", {31'b0, ex_valid}, 32'd0);
    checkOutput("d1_cnt_b", stall_cycles, 32'd2);
    mem_valid = 1'b0;
    wb_en = 1'b1; wb_index = 4'd3; wb_data = 32'h1234_5678;
    #1;
    checkOutput("d1_stall_c", {31'b0, stall_id}, 32'd0);
    stepCycle();
    wb_en = 1'b0;
    checkOutput("d1_cons_valid", {31'b0, ex_valid}, 32'd1);
    checkOutput("d1_cons_data", ex_rs1_data, 32'h1234_5678);
    checkOutput("d1_cons_rd", {28'b0, ex_rd}, 32'd7);
    checkOutput("d1_cnt_final", stall_cycles, 32'd2);

    // Same pair, but the consumer does not read r3.
    applyStimulus(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 8'h01, 32'h0, 32'h48);
    stepCycle();
    applyStimulus(1'b1, 4'd0, 1'b0, 4'd3, 1'b0, 4'd7, 8'h00, 32'h0, 32'h4C);
    checkOutput("nouse_stall", {31'b0, stall_id}, 32'd0);
    stepCycle();
    checkOutput("nouse_valid", {31'b0, ex_valid}, 32'd1);
    checkOutput("nouse_cnt", stall_cycles, 32'd2);

    // Distance 2: one bubble while the producer of r4 sits in MEM.
    applyStimulus(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 8'h01, 32'h0, 32'h50);
    stepCycle();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 32'h0, 32'h0);
    stepCycle();
    mem_valid = 1'b1; mem_regwr = 1'b1; mem_rd = 4'd4;
    applyStimulus(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd8, 8'h00, 32'h0, 32'h58);
    checkOutput("d2_stall", {31'b0, stall_id}, 32'd1);
    stepCycle();
    checkOutput("d2_bubble", {31'b0, ex_valid}, 32'd0);
    checkOutput("d2_cnt", stall_cycles, 32'd3);
    mem_valid = 1'b0;
    wb_en = 1'b1; wb_index = 4'd4; wb_data = 32'hA5A5_A5A5;
    stepCycle();
    wb_en = 1'b0;
    checkOutput("d2_cons_data", ex_rs0_data, 32'hA5A5_A5A5);

    // Flush together with an interlock: flush wins, no count.
    applyStimulus(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 8'h01, 32'h0, 32'h60);
    stepCycle();
    ex_flush = 1'b1;
    applyStimulus(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd9, 8'h00, 32'h0, 32'h64);
    checkOutput("fl_il_stall", {31'b0, stall_id}, 32'd1);
    stepCycle();
    ex_flush = 1'b0;
    checkOutput("fl_il_valid", {31'b0, ex_valid}, 32'd0);
    checkOutput("fl_il_rd", {28'b0, ex_rd}, 32'd0);
    checkOutput("fl_il_cnt", stall_cycles, 32'd3);
    stepCycle();
    checkOutput("fl_reload", {31'b0, ex_valid}, 32'd1);

    // Flush alone.
    ex_flush = 1'b1;
    applyStimulus(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 8'h00, 32'h0, 32'h68);
    checkOutput("fl_stall", {31'b0, stall_id}, 32'd0);
    stepCycle();
    ex_flush = 1'b0;
    checkOutput("fl_valid", {31'b0, ex_valid}, 32'd0);

    // Hold for three cycles while the decode inputs change underneath.
    applyStimulus(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd9, 8'h80, 32'h0000_1111, 32'h0000_0100);
    stepCycle();
    ex_hold = 1'b1;
    applyStimulus(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd2, 8'h02, 32'h0000_2222, 32'h0000_0200);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("hold_stall_%0d", c), {31'b0, stall_id}, 32'd1);
      stepCycle();
      checkOutput($sformatf("hold_valid_%0d", c), {31'b0, ex_valid}, 32'd1);
      checkOutput($sformatf("hold_rd_%0d", c), {28'b0, ex_rd}, 32'd9);
      checkOutput($sformatf("hold_imm_%0d", c), ex_imm, 32'h0000_1111);
      checkOutput($sformatf("hold_pc_%0d", c), ex_pc, 32'h0000_0100);
      checkOutput($sformatf("hold_ctrl_%0d", c), {24'b0, ex_ctrl}, 32'h80);
      checkOutput($sformatf("hold_data_%0d", c), ex_rs0_data, 32'hDEAD_BEEF);
    end
    ex_hold = 1'b0;
    stepCycle();
    checkOutput("post_hold_rd", {28'b0, ex_rd}, 32'd2);
    checkOutput("post_hold_data", ex_rs0_data, 32'h1234_5678);

    // Saturation: preload the counter just below the top, then interlock.
    mem_valid = 1'b1; mem_regwr = 1'b1; mem_rd = 4'd8;
    applyStimulus(1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 4'd1, 8'h00, 32'h0, 32'h70);
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    stepCycle();
    checkOutput("sat_reach", stall_cycles, 32'hFFFF_FFFF);
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput($sformatf("sat_hold_%0d", c), stall_cycles, 32'hFFFF_FFFF);
    end
    mem_valid = 1'b0;

    // Reset mid-operation drops the concurrent write and clears the file.
    reset = 1'b1;
    wb_en = 1'b1; wb_index = 4'd5; wb_data = 32'hCAFE_F00D;
    stepCycle();
    reset = 1'b0;
    wb_en = 1'b0;
    applyStimulus(1'b1, 4'd5, 1'b1, 4'd3, 1'b1, 4'd0, 8'h00, 32'h0, 32'h0);
    stepCycle();
    checkOutput("rst_mid_r5", ex_rs0_data, 32'd0);
    checkOutput("rst_mid_r3", ex_rs1_data, 32'd0);
    checkOutput("rst_mid_cnt", stall_cycles, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Decode-to-execute boundary of the pipeline, feeding the forwarding unit at the EX input.
- Holds the 16×32 architectural register file, with two read ports and one write port driven by writeback.
- Detects RAW hazards against in-flight producers in EX and MEM, and interlocks decode when it finds one.
- Registers operands, indices and control into the ID/EX pipeline register, supporting hold, flush and bubble insertion.
- Counts interlock cycles for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, datapath width
- IDX_W, 4, register index width (16 registers)
- CTRL_W, 8, opaque control bundle width; bit 0 = reg_wr

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode slot holds an instruction
- id_rs0, id_rs1  in  IDX_W  source indices
- id_use0, id_use1  in  1  source actually read
- id_rd  in  IDX_W  destination index
- id_imm  in  DATA_W  decoded immediate
- id_pc  in  DATA_W  instruction PC
- id_ctrl  in  CTRL_W  control bundle
- mem_valid, mem_regwr  in  1  MEM-stage producer status
- mem_rd  in  IDX_W  MEM-stage destination
- wb_en  in  1  writeback enable
- wb_index  in  IDX_W  writeback index
- wb_data  in  DATA_W  writeback data
- ex_hold  in  1  EX cannot accept (multi-cycle op)
- ex_flush  in  1  squash EX slot (taken branch)
- stall_id  out  1  decode must hold its instruction
- ex_valid  out  1  ID/EX slot valid
- ex_rs0_data, ex_rs1_data  out  DATA_W  operand values
- ex_rs0, ex_rs1, ex_rd  out  IDX_W  indices, forwarded to the forwarding unit
- ex_imm, ex_pc  out  DATA_W  registered copies
- ex_ctrl  out  CTRL_W  registered control
- stall_cycles  out  32  saturating interlock counter

## Operation
- Register file:
  - All 16 entries are writable; there is no hardwired zero.
  - Writes happen at the clk edge when wb_en is high.
  - Reads are combinational, with write-through: a read of index wb_index while wb_en is high returns wb_data.
- Hazard hit for producer stage X: X_valid && X_regwr && ((id_use0 && id_rs0==X_rd) || (id_use1 && id_rs1==X_rd)).
  - X=EX uses the internal ex_valid and ex_ctrl[0].
  - X=MEM uses the mem_* inputs.
- interlock = id_valid && (hit_ex || hit_mem).
- stall_id = interlock || ex_hold. It is combinational and is not asserted by flush alone.
- ID/EX update priority at each edge: reset > ex_flush > ex_hold > interlock > load.
  - reset: all ex_* outputs become 0; ex_valid = 0.
  - ex_flush: ex_valid <= 0; the other fields are don't-care but are cleared to 0.
  - ex_hold: all ex_* fields keep their values.
  - interlock: bubble, ex_valid <= 0.
  - load: ex_valid <= id_valid; all other fields are captured from id_* and the read ports.
- stall_cycles:
  - Increments on each edge where interlock is high and neither ex_hold nor ex_flush is high.
  - Saturates at 0xFFFFFFFF.
  - Resets to 0.
- Reset mid-operation: the register file clears to 0 and any pending write that cycle is dropped.

## Timing
- Operand capture latency is 1 cycle from the ID inputs to the ex_* outputs.
- A WB write is visible to a same-cycle ID read (write-through) and to all later reads.
- A WB write in the same cycle that a consumer sits in EX is not covered here; the downstream forwarding unit covers it.
- Dependency distance 1 (producer in EX):
  - 2 bubble cycles.
  - The producer moves to MEM, then to WB.
  - The consumer's read is satisfied by write-through.
- Dependency distance 2: 1 bubble cycle.
- Dependency distance 3 or more: no stall.
- ex_flush and interlock in the same cycle:
  - The flush wins.
  - The counter does not increment.
  - stall_id still reflects interlock.
- ex_hold and interlock together: hold, and stall_id = 1.
- Simultaneous wb_en to index k and an ID read of k on both ports: both ports return wb_data.

## Structure
- Shared package pp_pkg holds:
  - DATA_W, IDX_W, NUM_REGS=16 and CTRL_W.
  - The CTRL_REGWR bit position constant.
- Sub-module reg_file contains:
  - The 16-entry array.
  - Two write-through read ports and one write port.
  - The synchronous reset clear.
- Hazard logic, the ID/EX register and the counter live in decode_issue_stage.

## Test plan
- Reset, then read all 16 indices:
  - ex_rs0_data = ex_rs1_data = 0.
  - ex_valid = 0.
  - stall_cycles = 0.
- wb_en=1, wb_index=5, wb_data=0xDEADBEEF, with id_rs0=id_rs1=5 and id_valid=1 in the same cycle:
  - Next cycle ex_rs0_data = ex_rs1_data = 0xDEADBEEF.
  - ex_valid = 1.
- Producer with rd=3 and ctrl[0]=1, followed by consumer with id_rs1=3 and id_use1=1:
  - stall_id high for 2 cycles.
  - Two bubbles (ex_valid=0).
  - Consumer enters EX with the written value.
  - stall_cycles = 2.
- Same sequence with id_use1=0: no stall; stall_cycles unchanged.
- Flush and interlock together: ex_valid = 0 next cycle, and stall_cycles does not increment.
- Flush alone: ex_valid = 0 next cycle.
- ex_hold=1 for 3 cycles with a valid EX slot: all ex_* outputs are stable and stall_id = 1 throughout.
- Counter preloaded via a long interlock (force near 0xFFFFFFFF): stays at 0xFFFFFFFF.
